pipelined_rc_adder: RTL and testbench

Parametrised, pipelined ripple-carry add/subtract unit. It is the sequential successor to the 4-bit combinational ripple adder. The WIDTH-bit datapath is split into STAGES equal slices, and each slice resolves in its own register stage, with the carry passed stage to stage. A valid/ready handshake on both sides lets it sit between a producer and a consumer, with full backpressure.

---
 rtl/pipelined_rc_adder_pkg.sv | 18 +
 rtl/pipelined_rc_adder_if.sv | 28 ++
 rtl/pipelined_rc_adder_slice.sv | 27 ++
 rtl/pipelined_rc_adder.sv | 122 ++++++++++++
 tb/tb_pipelined_rc_adder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_rc_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry add/subtract unit.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // True when the datapath splits into whole, non-empty slices.
  function automatic bit width_ok(input int width, input int stages);
    if ((stages >= 1) && (stages <= width)) begin
      return (width % stages) == 0;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/pipelined_rc_adder_if.sv
// Producer/consumer handshake bundle for pipelined_rc_adder; the unit uses the slave side.
interface pipelined_rc_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/pipelined_rc_adder_slice.sv
// Combinational SLICE-bit ripple adder built from full-adder equations; one per pipeline stage.
module rc_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [SLICE:0] c_s;

  // Bit-serial carry ripple through the slice.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
    end
  end

  assign co       = c_s[SLICE];
  assign c_msb_in = c_s[SLICE-1];
endmodule

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry add/subtract: STAGES register stages, one SLICE-bit slice resolved per
// stage, carry handed stage to stage, global advance enable for full backpressure.
module pipelined_rc_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_rc_adder_if.slave bus
);
  localparam int SLICE = WIDTH / STAGES;

  if (!width_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_rc_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic adv_s;

  // One global enable: the pipe moves whenever the output slot is empty or being drained.
  assign adv_s = !g_stage[STAGES-1].vld_r || bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unresolved when they reach this stage.
    localparam int IN_W = WIDTH - k * SLICE;

    logic                   vld_in_s;
    logic                   c_in_s;
    logic [IN_W-1:0]        a_in_s;
    logic [IN_W-1:0]        b_in_s;
    logic [(k+1)*SLICE-1:0] sum_nxt_s;
    logic [SLICE-1:0]       slice_s;
    logic                   co_s;
    logic                   cm_s;
    logic                   vld_r;
    logic                   c_r;
    logic [(k+1)*SLICE-1:0] sum_r;

    if (k == 0) begin : g_head
      // Subtract is folded in here: b' = ~b and carry-in forced to 1, cin ignored.
      always_comb begin
        vld_in_s = bus.in_valid;
        a_in_s   = bus.a;
        if (bus.op == OP_SUB) begin
          b_in_s = ~bus.b;
          c_in_s = 1'b1;
        end else begin
          b_in_s = bus.b;
          c_in_s = bus.cin;
        end
      end
      assign sum_nxt_s = slice_s;
    end else begin : g_body
      assign vld_in_s  = g_stage[k-1].vld_r;
      assign c_in_s    = g_stage[k-1].c_r;
      assign a_in_s    = g_stage[k-1].g_fwd.a_r;
      assign b_in_s    = g_stage[k-1].g_fwd.b_r;
      assign sum_nxt_s = {slice_s, g_stage[k-1].sum_r};
    end

    rc_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a        (a_in_s[SLICE-1:0]),
      .b        (b_in_s[SLICE-1:0]),
      .cin      (c_in_s),
      .s        (slice_s),
      .co       (co_s),
      .c_msb_in (cm_s)
    );

    // Stage valid, slice carry and the growing partial sum.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (adv_s) begin
        vld_r <= vld_in_s;
        c_r   <= co_s;
        sum_r <= sum_nxt_s;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IN_W-SLICE-1:0] a_r;
      logic [IN_W-SLICE-1:0] b_r;
      logic                  cm_unused_s;

      assign cm_unused_s = cm_s;

      // Skew registers carry the not-yet-added upper operand bits alongside the partial sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv_s) begin
          a_r <= a_in_s[IN_W-1:SLICE];
          b_r <= b_in_s[IN_W-1:SLICE];
        end
      end
    end else begin : g_tail
      logic ovf_r;

      // Signed overflow from the carries into and out of the MSB of the last slice.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= co_s ^ cm_s;
        end
      end
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = g_stage[STAGES-1].vld_r;
  assign bus.s         = g_stage[STAGES-1].sum_r;
  assign bus.co        = g_stage[STAGES-1].c_r;
  assign bus.ovf       = g_stage[STAGES-1].g_tail.ovf_r;
endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Self-checking bench for pipelined_rc_adder (WIDTH=8, STAGES=2): directed table, throughput,
// backpressure, random traffic against an arithmetic scoreboard, and reset mid-flight.
module tb_pipelined_rc_adder;
  import adder_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } res_t;

  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ovf;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic acc = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  res_t exp_q[$];

  pipelined_rc_adder_if #(.WIDTH(W)) bus ();

  pipelined_rc_adder #(
    .WIDTH  (W),
    .STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true integer arithmetic, overflow = signed result out of 8-bit range.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input op_e op);
    int   full;
    int   sa;
    int   sb;
    int   sr;
    res_t r;
    sa = int'(a) - (a[7] ? 256 : 0);
    sb = int'(b) - (b[7] ? 256 : 0);
    if (op == OP_SUB) begin
      full = int'(a) - int'(b) + 256;
      sr   = sa - sb;
    end else begin
      full = int'(a) + int'(b) + int'(cin);
      sr   = sa + sb + int'(cin);
    end
    r.s   = full[7:0];
    r.co  = full[8];
    r.ovf = (sr > 127) || (sr < -128);
    return r;
  endfunction

  // Scoreboard: every accepted operand pair must come out once, in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("sb_result", 32'({bus.s, bus.co, bus.ovf}), 32'(exp_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.op));
      end
    end
  end

  task automatic drive_cycle(input int vpct, input logic ordy);
    @(posedge clk);
    #1;
    if (!bus.in_valid || acc) begin
      bus.in_valid = (int'($urandom_range(0, 99)) < vpct);
      bus.a        = 8'($urandom_range(0, 255));
      bus.b        = 8'($urandom_range(0, 255));
      bus.cin      = 1'($urandom_range(0, 1));
      bus.op       = op_e'($urandom_range(0, 1));
    end
    bus.out_ready = ordy;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 30 && (exp_q.size() != 0 || bus.in_valid); c++) begin
      drive_cycle(0, 1'b1);
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    res_t snap;
    int   first_c;
    int   last_c;
    int   cnt_c;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_outputs", 32'({bus.s, bus.co, bus.ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    tbl[0] = '{OP_ADD, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_slice_carry"};
    tbl[1] = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap"};
    tbl[2] = '{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf"};
    tbl[3] = '{OP_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, "sub_borrow"};
    tbl[4] = '{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_ovf"};
    tbl[5] = '{OP_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "add_cin"};
    tbl[6] = '{OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, "sub_cin_ignored"};
    tbl[7] = '{OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_neg_ovf"};

    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.op       = tbl[i].op;
      bus.a        = tbl[i].a;
      bus.b        = tbl[i].b;
      bus.cin      = tbl[i].cin;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check({tbl[i].name, "_lat1"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check({tbl[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tbl[i].name, "_s"}, 32'(bus.s), 32'(tbl[i].s));
      check({tbl[i].name, "_co"}, 32'(bus.co), 32'(tbl[i].co));
      check({tbl[i].name, "_ovf"}, 32'(bus.ovf), 32'(tbl[i].ovf));
    end

    first_c = -1;
    last_c  = -1;
    cnt_c   = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c < 16) begin
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 8'(c);
        bus.b        = 8'(2 * c);
        bus.cin      = c[0];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 16) begin
        check("tput_in_ready", 32'(bus.in_ready), 32'd1);
      end
      if (bus.out_valid) begin
        if (first_c < 0) begin
          first_c = c;
        end
        last_c = c;
        cnt_c++;
      end
    end
    check("tput_first_cycle", 32'(first_c), 32'd2);
    check("tput_count", 32'(cnt_c), 32'd16);
    check("tput_last_cycle", 32'(last_c), 32'd17);

    acc = 1'b0;
    repeat (3) drive_cycle(100, 1'b0);
    check("bp_full_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    snap = '{bus.s, bus.co, bus.ovf};
    repeat (5) begin
      drive_cycle(100, 1'b0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold", 32'({bus.s, bus.co, bus.ovf}), 32'(snap));
    end
    repeat (4) drive_cycle(100, 1'b1);
    drain("bp_drained");

    repeat (300) drive_cycle(70, ($urandom_range(0, 9) < 7));
    drain("rand_drained");

    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 8'h11;
    bus.b        = 8'h22;
    bus.cin      = 1'b0;
    @(posedge clk);
    #1 bus.a = 8'h33;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_s", 32'(bus.s), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_result", 32'(bus.out_valid), 32'd0);
    end
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
